bip_host_link: RTL and testbench
================================

BIP_HOST_LINK -- requirements
Module: bip_host_link

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16: clk cycles per serial bit, valid range 4..4095.
REQ-002 Parameter TIMEOUT_CYCLES, default 1000000: maximum wait for the first response start bit.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low; 0 forces the reset state immediately.
REQ-005 start  input  1  one-cycle request to send cmd_byte and collect the BIP result.
REQ-006 cmd_byte  input  8  command byte for the BIP UART, sampled in the cycle start=1.
REQ-007 rx_in  input  1  serial line driven by the BIP tx; idle high.
REQ-008 tx_out  output  1  serial line driving the BIP rx; idle high.
REQ-009 busy  output  1  high from the cycle after an accepted start until done or an error.
REQ-010 done  output  1  one-cycle pulse when all 4 result bytes have been received cleanly.
REQ-011 result_pc  output  11  received word bits [26:16], the final BIP PC.
REQ-012 result_acc  output  16  received word bits [15:0], the final BIP data word.
REQ-013 framing_err  output  1  sticky; a received stop bit was sampled low.
REQ-014 timeout_err  output  1  sticky; no response start bit arrived within TIMEOUT_CYCLES.

Function
REQ-015 Serial format SHALL be 8N1: start bit 0, data bits LSB first, one stop bit 1, each bit exactly CLKS_PER_BIT cycles.
REQ-016 FSM states: IDLE, TX, WAIT, RX, DONE.
- IDLE -> TX on start=1.
- TX -> WAIT after the stop bit completes.
- WAIT -> RX on a detected start bit.
- RX -> DONE after the 4th byte is received cleanly.
- DONE -> IDLE after one cycle.
REQ-017 An accepted start SHALL clear framing_err and timeout_err, and the first start-bit cycle SHALL appear on tx_out in the cycle after start.
REQ-018 start SHALL be ignored whenever the FSM is not in IDLE.
REQ-019 rx_in SHALL pass through a 2-flop synchronizer; a start bit is a high-to-low transition of the synchronized signal.
REQ-020 Each received bit SHALL be sampled at count CLKS_PER_BIT/2 (integer division) of its bit period.
REQ-021 If the start bit resamples high at mid-bit, it is a glitch: the receiver SHALL return to hunting without counting a byte.
REQ-022 Result byte order SHALL be little-endian: byte0=[7:0], byte1=[15:8], byte2=[23:16], byte3=[31:24].
REQ-023 Bits [31:27] SHALL be received and discarded.
REQ-024 result_pc and result_acc SHALL update only in the done cycle and hold until the next done or reset; partial results are never visible.
REQ-025 In WAIT, the timeout counter SHALL count from 0.
- Reaching TIMEOUT_CYCLES-1 without a start bit: set timeout_err, go to IDLE.
- A start bit in the same cycle as expiry takes precedence: no error.
REQ-026 No timeout SHALL apply between bytes in RX. Once the 4th byte completes, rx_in SHALL be ignored until the next accepted start.
REQ-027 A stop bit sampled 0 in any byte SHALL set framing_err and return the FSM to IDLE without a done pulse. Results are left unchanged.
REQ-028 rx_in activity while in IDLE or TX SHALL be discarded.
REQ-029 busy SHALL drop in the same cycle done pulses or an error flag sets.

Reset
REQ-030 On reset=0, regardless of state:
- tx_out=1, busy=0, done=0, result_pc=0, result_acc=0, framing_err=0, timeout_err=0.
- FSM in IDLE; all bit and baud counters at 0.
- Synchronizer flops at 1.
REQ-031 Reset asserted mid-frame SHALL abort the frame. The first frame after release starts only on a new start pulse.

Verification
REQ-032 start with cmd_byte=0xA5 -> tx_out shows 0,1,0,1,0,0,1,0,1,1, each for 16 cycles; busy=1 throughout.
REQ-033 Response bytes 0x34,0x12,0x2A,0xF8 -> done pulses once; result_acc=0x1234, result_pc=0x02A; bits 31:27 ignored.
REQ-034 Byte2 sent with stop bit 0 -> framing_err=1, no done pulse, results keep their previous values, busy=0.
REQ-035 TIMEOUT_CYCLES=100 and rx_in held at 1 -> timeout_err=1 exactly 100 cycles after entering WAIT.
- A second start clears the error and a full response completes normally.
REQ-036 8-cycle low glitch in WAIT, then a valid response -> glitch ignored; correct result with done pulsing once.
REQ-037 reset=0 during bit 5 of TX -> tx_out=1 in the same cycle.
- start during TX is ignored.
- After release, a new start produces a clean frame.

Source files
------------

// File: rtl/bip_host_link.sv
`default_nettype none
// ============================================================================
// Module   : bip_host_link
// Purpose  : Host-side serial link to a BIP processor. Sends one 8N1 command
//            byte, then collects a 4-byte little-endian result word and
//            presents the final PC (bits 26:16) and data word (bits 15:0).
// Revision : 1.0 - initial release
// ============================================================================
module bip_host_link #(
  parameter int CLKS_PER_BIT   = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  cmd_byte,
  input  logic        rx_in,
  output logic        tx_out,
  output logic        busy,
  output logic        done,
  output logic [10:0] result_pc,
  output logic [15:0] result_acc,
  output logic        framing_err,
  output logic        timeout_err
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_TX   = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_RX   = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [11:0] c_BIT_LAST = 12'(CLKS_PER_BIT - 1);
  localparam logic [11:0] c_BIT_MID  = 12'(CLKS_PER_BIT / 2);
  localparam logic [31:0] c_TO_LAST  = 32'(TIMEOUT_CYCLES - 1);

  logic [2:0]  state_q, state_d;
  logic [9:0]  tx_shift_q, tx_shift_d;   // bit 0 is the line level being driven
  logic [11:0] baud_q, baud_d;
  logic [3:0]  bit_q, bit_d;             // 0 = start, 1..8 = data, 9 = stop
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic        hunt_q, hunt_d;           // waiting for the next byte's start bit
  logic [7:0]  rx_byte_q, rx_byte_d;
  logic [23:0] word_q, word_d;           // first three received bytes
  logic [31:0] to_q, to_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [10:0] pc_q, pc_d;
  logic [15:0] acc_q, acc_d;
  logic        ferr_q, ferr_d;
  logic        terr_q, terr_d;
  logic        sync1_q, sync2_q, sync3_q;

  logic        w_fall;
  logic        w_wrap;
  logic [11:0] w_baud_next;

  assign w_fall      = sync3_q & ~sync2_q;
  assign w_wrap      = (baud_q == c_BIT_LAST);
  assign w_baud_next = w_wrap ? 12'd0 : baud_q + 12'd1;

  // Next-state logic for the transmit / wait / receive sequencer.
  always_comb begin
    state_d    = state_q;
    tx_shift_d = tx_shift_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    byte_cnt_d = byte_cnt_q;
    hunt_d     = hunt_q;
    rx_byte_d  = rx_byte_q;
    word_d     = word_q;
    to_d       = to_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pc_d       = pc_q;
    acc_d      = acc_q;
    ferr_d     = ferr_q;
    terr_d     = terr_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_TX;
          tx_shift_d = {1'b1, cmd_byte, 1'b0};
          baud_d     = 12'd0;
          bit_d      = 4'd0;
          byte_cnt_d = 2'd0;
          busy_d     = 1'b1;
          ferr_d     = 1'b0;
          terr_d     = 1'b0;
        end
      end
      S_TX: begin
        baud_d = w_baud_next;
        if (w_wrap) begin
          // Shifting in ones leaves the line idle once the stop bit is gone.
          tx_shift_d = {1'b1, tx_shift_q[9:1]};
          if (bit_q == 4'd9) begin
            state_d = S_WAIT;
            bit_d   = 4'd0;
            to_d    = 32'd0;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      S_WAIT: begin
        // A start edge wins over an expiring timeout in the same cycle.
        if (w_fall) begin
          state_d = S_RX;
          hunt_d  = 1'b0;
          baud_d  = 12'd1;  // the edge cycle itself was count 0
          bit_d   = 4'd0;
        end else if (to_q == c_TO_LAST) begin
          state_d = S_IDLE;
          terr_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          to_d = to_q + 32'd1;
        end
      end
      S_RX: begin
        if (hunt_q) begin
          if (w_fall) begin
            hunt_d = 1'b0;
            baud_d = 12'd1;
            bit_d  = 4'd0;
          end
        end else begin
          baud_d = w_baud_next;
          if (w_wrap) bit_d = bit_q + 4'd1;
          if (baud_q == c_BIT_MID) begin
            if (bit_q == 4'd0) begin
              // Start bit high again at mid-bit: treat as a glitch.
              if (sync2_q) begin
                if (byte_cnt_q == 2'd0) state_d = S_WAIT;
                else                    hunt_d  = 1'b1;
              end
            end else if (bit_q <= 4'd8) begin
              rx_byte_d = {sync2_q, rx_byte_q[7:1]};
            end else if (!sync2_q) begin
              state_d = S_IDLE;
              ferr_d  = 1'b1;
              busy_d  = 1'b0;
            end else if (byte_cnt_q == 2'd3) begin
              // Bits 31:27 of the word (rx_byte_q[7:3]) are dropped here.
              state_d = S_DONE;
              done_d  = 1'b1;
              busy_d  = 1'b0;
              pc_d    = {rx_byte_q[2:0], word_q[23:16]};
              acc_d   = word_q[15:0];
            end else begin
              word_d     = {rx_byte_q, word_q[23:8]};
              byte_cnt_d = byte_cnt_q + 2'd1;
              hunt_d     = 1'b1;
            end
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset returns the line to idle immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      tx_shift_q <= '1;
      baud_q     <= '0;
      bit_q      <= '0;
      byte_cnt_q <= '0;
      hunt_q     <= 1'b0;
      rx_byte_q  <= '0;
      word_q     <= '0;
      to_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pc_q       <= '0;
      acc_q      <= '0;
      ferr_q     <= 1'b0;
      terr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_shift_q <= tx_shift_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      byte_cnt_q <= byte_cnt_d;
      hunt_q     <= hunt_d;
      rx_byte_q  <= rx_byte_d;
      word_q     <= word_d;
      to_q       <= to_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pc_q       <= pc_d;
      acc_q      <= acc_d;
      ferr_q     <= ferr_d;
      terr_q     <= terr_d;
    end
  end

  // Two-flop synchronizer plus one history flop for falling-edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      sync3_q <= 1'b1;
    end else begin
      sync1_q <= rx_in;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign tx_out      = tx_shift_q[0];
  assign busy        = busy_q;
  assign done        = done_q;
  assign result_pc   = pc_q;
  assign result_acc  = acc_q;
  assign framing_err = ferr_q;
  assign timeout_err = terr_q;

endmodule
`default_nettype wire

// File: tb/tb_bip_host_link.sv
`default_nettype none
// ============================================================================
// Module   : tb_bip_host_link
// Purpose  : Self-checking bench for bip_host_link (directed + random frames
//            against a word-level reference model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bip_host_link;

  localparam int CPB = 16;
  localparam int TO  = 100;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  cmd_byte = 8'h00;
  logic        rx_in = 1'b1;
  logic        tx_out, busy, done, framing_err, timeout_err;
  logic [10:0] result_pc;
  logic [15:0] result_acc;

  int pass_cnt = 0;
  int total_cnt = 0;
  int done_cnt = 0;
  int busy_at_done = 0;
  int res_change = 0;
  logic [26:0] prev_res = '0;
  logic [10:0] exp_pc = '0;
  logic [15:0] exp_acc = '0;

  bip_host_link #(.CLKS_PER_BIT(CPB), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .cmd_byte(cmd_byte),
    .rx_in(rx_in), .tx_out(tx_out), .busy(busy), .done(done),
    .result_pc(result_pc), .result_acc(result_acc),
    .framing_err(framing_err), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Observe done pulses and result stability at the falling edge.
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      if (busy) busy_at_done++;
    end
    if (reset && !done && ({result_pc, result_acc} !== prev_res)) res_change++;
    prev_res = {result_pc, result_acc};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Line level expected for frame bit idx of an 8N1 frame carrying cmd.
  function automatic logic exp_tx_bit(input logic [7:0] cmd, input int idx);
    if (idx == 0) return 1'b0;
    if (idx >= 9) return 1'b1;
    return cmd[idx-1];
  endfunction

  // Pulse start and check the full command frame plus busy on every cycle.
  task automatic send_cmd(input logic [7:0] cmd);
    start = 1'b1;
    cmd_byte = cmd;
    tick();
    start = 1'b0;
    cmd_byte = 8'($urandom);
    chk("err_cleared", {30'd0, framing_err, timeout_err}, 32'd0);
    for (int c = 0; c < 10 * CPB; c++) begin
      chk("tx_bit", 32'(tx_out), 32'(exp_tx_bit(cmd, c / CPB)));
      chk("tx_busy", 32'(busy), 32'd1);
      tick();
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    for (int i = 0; i < 10; i++) begin
      rx_in = (i == 0) ? 1'b0 : (i == 9) ? stop : b[i-1];
      repeat (CPB) tick();
    end
    rx_in = 1'b1;
  endtask

  // One complete transaction; bad_stop selects a byte with a low stop bit.
  task automatic run_txn(input logic [7:0] cmd, input logic [31:0] word,
                         input int bad_stop, input bit glitch);
    int d0;
    logic [7:0] b;
    d0 = done_cnt;
    send_cmd(cmd);
    if (glitch) begin
      rx_in = 1'b0;
      repeat (8) tick();
      rx_in = 1'b1;
      repeat (20) tick();
    end
    for (int k = 0; k < 4; k++) begin
      b = word[8*k +: 8];
      send_byte(b, k != bad_stop);
    end
    repeat (4) tick();
    if (bad_stop < 0) begin
      exp_acc = 16'(word % 65536);
      exp_pc  = 11'((word >> 16) % 2048);
      chk("done_once", 32'(done_cnt - d0), 32'd1);
      chk("ferr_clean", 32'(framing_err), 32'd0);
    end else begin
      chk("no_done", 32'(done_cnt - d0), 32'd0);
      chk("ferr_set", 32'(framing_err), 32'd1);
    end
    chk("timeout_clean", 32'(timeout_err), 32'd0);
    chk("busy_after", 32'(busy), 32'd0);
    chk("result_acc", 32'(result_acc), 32'(exp_acc));
    chk("result_pc", 32'(result_pc), 32'(exp_pc));
  endtask

  initial begin
    logic [7:0] c;
    // Reset state
    repeat (3) tick();
    chk("rst_tx", 32'(tx_out), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_res", {5'd0, result_pc, result_acc}, 32'd0);
    chk("rst_errs", {30'd0, framing_err, timeout_err}, 32'd0);
    reset = 1'b1;
    repeat (3) tick();

    // Reference transaction
    run_txn(8'hA5, 32'hF82A1234, -1, 1'b0);
    chk("ref_acc", 32'(result_acc), 32'h1234);
    chk("ref_pc", 32'(result_pc), 32'h02A);

    // Framing error on byte 2; later bytes arrive while idle
    run_txn(8'($urandom), $urandom, 2, 1'b0);

    // Timeout: nothing answers
    send_cmd(8'($urandom));
    repeat (TO - 1) tick();
    chk("to_not_yet", 32'(timeout_err), 32'd0);
    chk("to_busy", 32'(busy), 32'd1);
    tick();
    chk("to_set", 32'(timeout_err), 32'd1);
    chk("to_busy_drop", 32'(busy), 32'd0);
    run_txn(8'($urandom), $urandom, -1, 1'b0);

    // Glitch in WAIT then a valid response
    run_txn(8'($urandom), $urandom, -1, 1'b1);

    // Reset during bit 5 of TX, with an ignored start during bit 2
    c = 8'($urandom);
    start = 1'b1;
    cmd_byte = c;
    tick();
    start = 1'b0;
    for (int k = 0; k < 5 * CPB + 4; k++) begin
      chk("tx2_bit", 32'(tx_out), 32'(exp_tx_bit(c, k / CPB)));
      start = (k == 2 * CPB + 3);
      cmd_byte = ~c;
      tick();
    end
    start = 1'b0;
    reset = 1'b0;
    #1;
    chk("arst_tx", 32'(tx_out), 32'd1);
    chk("arst_busy", 32'(busy), 32'd0);
    repeat (3) tick();
    reset = 1'b1;
    exp_pc = '0;
    exp_acc = '0;
    chk("arst_res", {5'd0, result_pc, result_acc}, 32'd0);
    for (int k = 0; k < 30; k++) begin
      tick();
      chk("post_rst_idle", {30'd0, tx_out, busy}, 32'd2);
    end
    run_txn(8'($urandom), $urandom, -1, 1'b0);

    // Random transactions
    for (int n = 0; n < 3; n++) run_txn(8'($urandom), $urandom, -1, 1'b0);

    chk("busy_at_done", 32'(busy_at_done), 32'd0);
    chk("partial_result", 32'(res_change), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
